// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   stall_bus_t  : per-register hold vector, bit0 PC .. bit4 MEM/WB, bit5 reserved.
//   STALL_*      : canonical stall patterns, one per requesting stage.
//   ctrl_state_e : controller state encoding (2-bit).
package pipe_ctrl_pkg;

  typedef logic [5:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE     = 6'b000000;
  localparam stall_bus_t STALL_FROM_ID  = 6'b000111;
  localparam stall_bus_t STALL_FROM_EX  = 6'b001111;
  localparam stall_bus_t STALL_FROM_MEM = 6'b011111;

  typedef enum logic [1:0] {
    CTRL_RUN     = 2'd0,
    CTRL_EX_WAIT = 2'd1,
    CTRL_FLUSH   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_perf_cnt.sv
// Saturating event counter used for stall-cycle accounting.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   clr_i    : synchronous clear, wins over inc_i
//   inc_i    : count this cycle
//   cnt_o    : current count, sticks at all-ones
module stall_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [PERF_W-1:0] cnt_o
);

  logic [PERF_W-1:0] cnt_q;
  logic [PERF_W-1:0] cnt_d;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage core.
// Merges ID/EX/MEM stall requests into one hold vector, sequences
// multi-cycle EX operations, issues a one-cycle flush with redirect PC
// and counts stalled cycles.
//   clk, rst        : clock, synchronous active-high reset
//   stallreq_id_i   : ID load-use hazard (level)
//   ex_start_i      : EX starts an op this cycle, length on ex_len_i
//   mem_busy_i      : MEM waiting on memory (level)
//   flush_req_i     : redirect request, target on flush_pc_i
//   stall_o         : per-register hold vector (combinational)
//   flush_o         : clear all pipeline registers this cycle
//   new_pc_o        : redirect target, valid with flush_o
//   ex_busy_o       : multi-cycle op in progress
//   ex_done_o       : multi-cycle op completes this cycle
//   ex_abort_o      : multi-cycle op was killed by the current flush
//   ex_err_o        : sticky, ex_start_i seen while busy
//   stall_cycles_o  : saturating count of cycles with stall_o[0]=1
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LEN_W  = 6,
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              ex_start_i,
  input  logic [LEN_W-1:0]  ex_len_i,
  input  logic              mem_busy_i,
  input  logic              flush_req_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              ex_busy_o,
  output logic              ex_done_o,
  output logic              ex_abort_o,
  output logic              ex_err_o,
  output logic [PERF_W-1:0] stall_cycles_o
);

  ctrl_state_e       state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] new_pc_q, new_pc_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;

  logic              ex_start_long;
  logic              ex_stall;
  logic              ex_last;
  stall_bus_t        stall_vec;

  // Stall vector and completion detect: purely a function of the current
  // state and inputs, so a pending flush request does not alter them.
  always_comb begin
    ex_start_long = ex_start_i && (ex_len_i >= LEN_W'(2));
    ex_last       = (state_q == CTRL_EX_WAIT) && (cnt_q == LEN_W'(1));
    ex_stall      = ((state_q == CTRL_RUN) && ex_start_long) ||
                    ((state_q == CTRL_EX_WAIT) && (cnt_q >= LEN_W'(2)));

    stall_vec = STALL_NONE;
    if (state_q == CTRL_FLUSH) begin
      stall_vec = STALL_NONE;
    end else if (mem_busy_i) begin
      stall_vec = STALL_FROM_MEM;
    end else if (ex_stall) begin
      stall_vec = STALL_FROM_EX;
    end else if (stallreq_id_i) begin
      stall_vec = STALL_FROM_ID;
    end
  end

  // Next-state logic. A flush request overrides every transition computed
  // above it, including any ex_start_i in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    abort_d  = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      CTRL_RUN: begin
        // Lengths 0 and 1 complete inside the normal EX slot.
        if (ex_start_long) begin
          cnt_d   = ex_len_i - LEN_W'(1);
          state_d = CTRL_EX_WAIT;
        end
      end
      CTRL_EX_WAIT: begin
        if (ex_start_i) begin
          err_d = 1'b1;
        end
        // Memory back-pressure freezes the op in place.
        if (!mem_busy_i) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = CTRL_RUN;
          end
        end
      end
      CTRL_FLUSH: begin
        state_d = CTRL_RUN;
      end
      default: begin
        state_d = CTRL_RUN;
      end
    endcase

    if (flush_req_i) begin
      state_d  = CTRL_FLUSH;
      new_pc_d = flush_pc_i;
      cnt_d    = '0;
      abort_d  = (state_q == CTRL_EX_WAIT);
      err_d    = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CTRL_RUN;
      cnt_q    <= '0;
      new_pc_q <= '0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
    end
  end

  stall_perf_cnt #(
    .PERF_W (PERF_W)
  ) u_stall_perf_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (stall_vec[0]),
    .cnt_o (stall_cycles_o)
  );

  assign stall_o    = stall_vec;
  assign flush_o    = (state_q == CTRL_FLUSH);
  assign new_pc_o   = new_pc_q;
  assign ex_busy_o  = (state_q == CTRL_EX_WAIT);
  assign ex_done_o  = ex_last && !mem_busy_i;
  assign ex_abort_o = abort_q;
  assign ex_err_o   = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one continuous table of per-cycle vectors
// plus a hand-written saturation sequence on a narrow counter instance.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i;
  logic        ex_start_i;
  logic [5:0]  ex_len_i;
  logic        mem_busy_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        ex_busy_o;
  logic        ex_done_o;
  logic        ex_abort_o;
  logic        ex_err_o;
  logic [31:0] stall_cycles_o;

  logic        sp_clr;
  logic        sp_inc;
  logic [2:0]  sp_cnt;

  int tests  = 0;
  int failed = 0;
  int vidx   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.LEN_W(6), .ADDR_W(32), .PERF_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .ex_start_i     (ex_start_i),
    .ex_len_i       (ex_len_i),
    .mem_busy_i     (mem_busy_i),
    .flush_req_i    (flush_req_i),
    .flush_pc_i     (flush_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .ex_busy_o      (ex_busy_o),
    .ex_done_o      (ex_done_o),
    .ex_abort_o     (ex_abort_o),
    .ex_err_o       (ex_err_o),
    .stall_cycles_o (stall_cycles_o)
  );

  stall_perf_cnt #(.PERF_W(3)) u_sp (
    .clk   (clk),
    .rst   (rst),
    .clr_i (sp_clr),
    .inc_i (sp_inc),
    .cnt_o (sp_cnt)
  );

  typedef struct {
    logic        r;
    logic        id;
    logic        st;
    logic [5:0]  len;
    logic        mb;
    logic        fr;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        fl;
    logic [31:0] npc;
    logic        busy;
    logic        done;
    logic        ab;
    logic        err;
    logic [31:0] perf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, id, st, input logic [5:0] len, input logic mb, fr,
    input logic [31:0] pc, input logic [5:0] stall, input logic fl,
    input logic [31:0] npc, input logic busy, done, ab, err,
    input logic [31:0] perf);
    vec_t v;
    v.r = r; v.id = id; v.st = st; v.len = len; v.mb = mb; v.fr = fr;
    v.pc = pc; v.stall = stall; v.fl = fl; v.npc = npc; v.busy = busy;
    v.done = done; v.ab = ab; v.err = err; v.perf = perf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, vidx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_id_i = 0; ex_start_i = 0; ex_len_i = 0;
    mem_busy_i = 0; flush_req_i = 0; flush_pc_i = 0; sp_clr = 0; sp_inc = 0;

    //                r id st len mb fr pc          stall    fl npc      bsy dn ab er perf
    // reset state
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  0,0,0,0,0));
    // ID stall for two cycles
    vecs.push_back(mk(0,1,0,0,0,0,32'h0,   6'h07,0,32'h0,  0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,32'h0,   6'h07,0,32'h0,  0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  0,0,0,0,2));
    // len-4 op
    vecs.push_back(mk(0,0,1,4,0,0,32'h0,   6'h0F,0,32'h0,  0,0,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h0F,0,32'h0,  1,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h0F,0,32'h0,  1,0,0,0,4));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  1,1,0,0,5));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  0,0,0,0,5));
    // single-cycle op
    vecs.push_back(mk(0,0,1,1,0,0,32'h0,   6'h00,0,32'h0,  0,0,0,0,5));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  0,0,0,0,5));
    // len-3 op with memory wait in its first EX_WAIT cycle
    vecs.push_back(mk(0,0,1,3,0,0,32'h0,   6'h0F,0,32'h0,  0,0,0,0,5));
    vecs.push_back(mk(0,0,0,0,1,0,32'h0,   6'h1F,0,32'h0,  1,0,0,0,6));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h0F,0,32'h0,  1,0,0,0,7));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  1,1,0,0,8));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  0,0,0,0,8));
    // mem stall outranks ID stall
    vecs.push_back(mk(0,0,0,0,1,0,32'h0,   6'h1F,0,32'h0,  0,0,0,0,8));
    vecs.push_back(mk(0,1,0,0,1,0,32'h0,   6'h1F,0,32'h0,  0,0,0,0,9));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  0,0,0,0,10));
    // flush abort of len-5 op
    vecs.push_back(mk(0,0,1,5,0,0,32'h0,   6'h0F,0,32'h0,  0,0,0,0,10));
    vecs.push_back(mk(0,0,0,0,0,1,32'h180, 6'h0F,0,32'h0,  1,0,0,0,11));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,1,32'h180,0,0,1,0,12));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h180,0,0,0,0,12));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h180,0,0,0,0,12));
    // back-to-back flush
    vecs.push_back(mk(0,0,0,0,0,1,32'h100, 6'h00,0,32'h180,0,0,0,0,12));
    vecs.push_back(mk(0,0,0,0,0,1,32'h200, 6'h00,1,32'h100,0,0,0,0,12));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,1,32'h200,0,0,0,0,12));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h200,0,0,0,0,12));
    // flush in the cnt==1 cycle: done and abort both fire
    vecs.push_back(mk(0,0,1,2,0,0,32'h0,   6'h0F,0,32'h200,0,0,0,0,12));
    vecs.push_back(mk(0,0,0,0,0,1,32'h40,  6'h00,0,32'h200,1,1,0,0,13));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,1,32'h40, 0,0,1,0,13));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h40, 0,0,0,0,13));
    // flush from RUN under ID stall; FLUSH masks the stall
    vecs.push_back(mk(0,1,0,0,0,1,32'h80,  6'h07,0,32'h40, 0,0,0,0,13));
    vecs.push_back(mk(0,1,0,0,0,0,32'h0,   6'h00,1,32'h80, 0,0,0,0,14));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h80, 0,0,0,0,14));
    // ex_start in the flush request cycle is dropped
    vecs.push_back(mk(0,0,1,4,0,1,32'h90,  6'h0F,0,32'h80, 0,0,0,0,14));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,1,32'h90, 0,0,0,0,15));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h90, 0,0,0,0,15));
    // start while busy sets sticky error
    vecs.push_back(mk(0,0,1,3,0,0,32'h0,   6'h0F,0,32'h90, 0,0,0,0,15));
    vecs.push_back(mk(0,0,1,3,0,0,32'h0,   6'h0F,0,32'h90, 1,0,0,0,16));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h90, 1,1,0,1,17));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h90, 0,0,0,1,17));
    // reset mid-op
    vecs.push_back(mk(0,0,1,5,0,0,32'h0,   6'h0F,0,32'h90, 0,0,0,1,17));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h0F,0,32'h90, 1,0,0,1,18));
    vecs.push_back(mk(1,0,0,0,0,0,32'h0,   6'h0F,0,32'h90, 1,0,0,1,19));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0,   6'h00,0,32'h0,  0,0,0,0,0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vidx          = i;
      rst           = vecs[i].r;
      stallreq_id_i = vecs[i].id;
      ex_start_i    = vecs[i].st;
      ex_len_i      = vecs[i].len;
      mem_busy_i    = vecs[i].mb;
      flush_req_i   = vecs[i].fr;
      flush_pc_i    = vecs[i].pc;
      @(negedge clk);
      chk("stall_o",        32'(stall_o),    32'(vecs[i].stall));
      chk("flush_o",        32'(flush_o),    32'(vecs[i].fl));
      chk("new_pc_o",       new_pc_o,        vecs[i].npc);
      chk("ex_busy_o",      32'(ex_busy_o),  32'(vecs[i].busy));
      chk("ex_done_o",      32'(ex_done_o),  32'(vecs[i].done));
      chk("ex_abort_o",     32'(ex_abort_o), 32'(vecs[i].ab));
      chk("ex_err_o",       32'(ex_err_o),   32'(vecs[i].err));
      chk("stall_cycles_o", stall_cycles_o,  vecs[i].perf);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // Saturation of the counter on a 3-bit instance.
    vidx = 1000;
    sp_inc = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("perf_cnt_6", 32'(sp_cnt), 32'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("perf_cnt_sat", 32'(sp_cnt), 32'd7);
    sp_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("perf_cnt_clr_wins", 32'(sp_cnt), 32'd0);
    sp_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("perf_cnt_after_clr", 32'(sp_cnt), 32'd1);
    sp_inc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Merges stall requests from ID (load-use), EX (multi-cycle ALU ops) and MEM (memory wait) into one stall vector.
- Sequences multi-cycle EX operations with a down-counter.
- Issues a registered one-cycle pipeline flush with a redirect PC.
- Keeps a saturating stall-cycle counter.

Parameters:
- LEN_W, 6: width of the multi-cycle length field.
- ADDR_W, 32: instruction address width; matches InstAddrBus.
- PERF_W, 32: stall-cycle counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- stallreq_id_i  in  1  ID stage hazard stall request (combinational, level).
- ex_start_i  in  1  one-cycle pulse: EX begins a multi-cycle op this cycle.
- ex_len_i  in  LEN_W  total EX occupancy in cycles; sampled with ex_start_i.
- mem_busy_i  in  1  MEM stage waiting on memory (level).
- flush_req_i  in  1  exception/redirect request (level, sampled each cycle).
- flush_pc_i  in  ADDR_W  redirect target; sampled with flush_req_i.
- stall_o  out  6  bit0 PC hold, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
- flush_o  out  1  clear all pipeline registers this cycle.
- new_pc_o  out  ADDR_W  redirect PC; valid while flush_o=1.
- ex_busy_o  out  1  a multi-cycle op is in progress (state EX_WAIT).
- ex_done_o  out  1  one-cycle pulse: multi-cycle op completes.
- ex_abort_o  out  1  one-cycle pulse: multi-cycle op killed by flush.
- ex_err_o  out  1  sticky flag: ex_start_i seen while already busy.
- stall_cycles_o  out  PERF_W  cycles with stall_o[0]=1, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - state=RUN, cnt=0.
  - stall_o=0, flush_o=0, new_pc_o=0.
  - ex_busy_o=0, ex_done_o=0, ex_abort_o=0, ex_err_o=0, stall_cycles_o=0.
  - Reset mid-op discards the op with no ex_done_o/ex_abort_o pulse.
- States: RUN, EX_WAIT, FLUSH.
- stall_o is combinational from state and inputs. Priority, highest first:
  - state FLUSH -> 000000.
  - mem_busy_i -> 011111.
  - EX stall -> 001111.
  - stallreq_id_i -> 000111.
  - otherwise -> 000000.
- EX stall is asserted when:
  - RUN with ex_start_i=1 and ex_len_i>=2; or
  - EX_WAIT with cnt>=2.
- RUN:
  - ex_start_i=1 with ex_len_i>=2: cnt<=ex_len_i-1, go to EX_WAIT.
  - ex_start_i=1 with ex_len_i of 0 or 1: single-cycle op; ex_done_o=0, no state change.
- EX_WAIT:
  - ex_busy_o=1.
  - cnt decrements each cycle unless mem_busy_i=1, in which case it holds.
  - When cnt==1 and mem_busy_i=0: ex_done_o=1 that cycle, no EX stall, next state RUN.
  - ex_start_i=1 in EX_WAIT: ignored, and ex_err_o<=1.
  - Latency: a len-N op stalls upstream for N-1 cycles; ex_done_o fires N-1 cycles after ex_start_i when mem_busy_i=0 throughout.
- Flush:
  - flush_req_i=1 in any state: the next state is FLUSH, new_pc_o<=flush_pc_i, cnt<=0.
  - Current-cycle outputs are unaffected by the request.
  - ex_start_i in the request cycle is ignored.
  - FLUSH lasts one cycle: flush_o=1, stall_o=0, next state RUN.
  - flush_req_i=1 during FLUSH: remain in FLUSH and recapture new_pc_o.
  - new_pc_o holds its last value outside FLUSH.
- Abort:
  - ex_abort_o=1 in the FLUSH cycle if the request arrived while in EX_WAIT, including the cnt==1 cycle.
  - In that cnt==1 case ex_done_o still pulses in the request cycle.
- Simultaneous events:
  - mem_busy_i with an EX stall: 011111 and cnt frozen.
  - flush_req_i overrides all state transitions.
- stall_cycles_o increments when stall_o[0]=1 and saturates at all-ones.

Decomposition:
- defines.v gains:
  - StallBus [5:0].
  - STALL_NONE 6'b000000, STALL_FROM_ID 6'b000111, STALL_FROM_EX 6'b001111, STALL_FROM_MEM 6'b011111.
  - CTRL_RUN, CTRL_EX_WAIT, CTRL_FLUSH (2-bit state codes).
- Sub-module stall_perf_cnt: saturating counter with inc/clear.

Test Plan:
- ID stall: stallreq_id_i=1 for 2 cycles -> stall_o=000111 for 2 cycles, then 000000; stall_cycles_o=2.
- Multi-cycle op: ex_start_i=1, ex_len_i=4 -> stall_o=001111 for 3 cycles (cycles 0-2), ex_busy_o=1 in cycles 1-3, ex_done_o=1 in cycle 3, cycle 4 in RUN.
- MEM during EX: ex_len_i=3, mem_busy_i=1 in cycle 1 -> stall_o=011111 in cycle 1; cnt holds at 2; ex_done_o moves from cycle 2 to cycle 3.
- Flush abort: flush_req_i=1, flush_pc_i=32'h0000_0180 in cycle 1 of an ex_len_i=5 op -> cycle 2: flush_o=1, new_pc_o=0x180, ex_abort_o=1, stall_o=0; ex_done_o never fires; cycle 3 in RUN.
- Back-to-back flush: flush_req_i=1 in two consecutive cycles with PCs 0x100 then 0x200 -> flush_o high 2 cycles, new_pc_o=0x100 then 0x200.
- Error and reset: ex_start_i during EX_WAIT -> ex_err_o=1 and sticky; rst=1 mid-op -> all outputs 0 next cycle and ex_err_o cleared.
